// File: rtl/matmul_seq.sv
// matmul_seq: sequential signed matrix multiply res = A x B, one MAC per cycle.
// Define MATMUL_SAT_EN to saturate out-of-range results instead of wrapping.
module matmul_seq #(
  parameter int A_ROWS = 2,
  parameter int A_COLS = 2,
  parameter int B_COLS = 2,
  parameter int DW = 8,
  parameter int RW = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [A_ROWS*A_COLS*DW-1:0]    a,
  input  logic [A_COLS*B_COLS*DW-1:0]    b,
  output logic [A_ROWS*B_COLS*RW-1:0]    res,
  output logic                           busy,
  output logic                           done,
  output logic                           ovf
);
  localparam int AW = 2*DW + $clog2(A_COLS);
  localparam int WW = (AW > RW ? AW : RW) + 1;
  localparam int IW = A_ROWS > 1 ? $clog2(A_ROWS) : 1;
  localparam int JW = B_COLS > 1 ? $clog2(B_COLS) : 1;
  localparam int KW = A_COLS > 1 ? $clog2(A_COLS) : 1;
  localparam logic signed [WW-1:0] HI = {{(WW-RW+1){1'b0}}, {(RW-1){1'b1}}};
  localparam logic signed [WW-1:0] LO = {{(WW-RW+1){1'b1}}, {(RW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, STORE, DONE} state_e;

  state_e                         state_q;
  logic [A_ROWS*A_COLS*DW-1:0]    a_q;
  logic [A_COLS*B_COLS*DW-1:0]    b_q;
  logic signed [AW-1:0]           acc_q, acc_d;
  logic [IW-1:0]                  i_q;
  logic [JW-1:0]                  j_q;
  logic [KW-1:0]                  k_q;
  logic signed [RW-1:0]           res_q [A_ROWS][B_COLS];
  logic                           busy_q, done_q, ovf_q;
  logic signed [DW-1:0]           am [A_ROWS][A_COLS];
  logic signed [DW-1:0]           bm [A_COLS][B_COLS];
  logic signed [WW-1:0]           acc_x;
  logic signed [RW-1:0]           narrow_d;
  logic                           hi_ov, lo_ov, last_i, last_j, last_k;

  always_comb begin
    for (int r = 0; r < A_ROWS; r++)
      for (int c = 0; c < A_COLS; c++)
        am[r][c] = a_q[DW*(A_ROWS*A_COLS-1-(r*A_COLS+c)) +: DW];
    for (int r = 0; r < A_COLS; r++)
      for (int c = 0; c < B_COLS; c++)
        bm[r][c] = b_q[DW*(A_COLS*B_COLS-1-(r*B_COLS+c)) +: DW];
    res = '0;
    for (int r = 0; r < A_ROWS; r++)
      for (int c = 0; c < B_COLS; c++)
        res[RW*(A_ROWS*B_COLS-1-(r*B_COLS+c)) +: RW] = res_q[r][c];
  end

  // operands are widened before multiplying so the product keeps full precision
  always_comb begin
    acc_d = acc_q + AW'(am[i_q][k_q]) * AW'(bm[k_q][j_q]);
    acc_x = WW'(acc_q);
    hi_ov = acc_x > HI;
    lo_ov = acc_x < LO;
`ifdef MATMUL_SAT_EN
    narrow_d = hi_ov ? RW'(HI) : lo_ov ? RW'(LO) : RW'(acc_x);
`else
    narrow_d = RW'(acc_x);
`endif
    last_i = i_q == IW'(A_ROWS-1);
    last_j = j_q == JW'(B_COLS-1);
    last_k = k_q == KW'(A_COLS-1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      res_q   <= '{default: '0};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          a_q     <= a;
          b_q     <= b;
          acc_q   <= '0;
          i_q     <= '0;
          j_q     <= '0;
          k_q     <= '0;
          ovf_q   <= 1'b0;
          busy_q  <= 1'b1;
          state_q <= MAC;
        end
        MAC: begin
          acc_q   <= acc_d;
          k_q     <= k_q + 1'b1;
          state_q <= last_k ? STORE : MAC;
        end
        STORE: begin
          res_q[i_q][j_q] <= narrow_d;
          ovf_q   <= ovf_q | hi_ov | lo_ov;
          acc_q   <= '0;
          k_q     <= '0;
          j_q     <= last_j ? '0 : j_q + 1'b1;
          i_q     <= last_j ? (last_i ? '0 : i_q + 1'b1) : i_q;
          done_q  <= last_i && last_j;
          state_q <= (last_i && last_j) ? DONE : MAC;
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_matmul_seq.sv
// tb_matmul_seq: randomized and directed checks of matmul_seq against an arithmetic reference.
module tb_matmul_seq;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] a, b;
  logic [63:0] res;
  logic        busy, done, ovf;
  int          n_chk = 0;
  int          n_pass = 0;

  localparam logic [31:0] BA = 32'h01020304;
  localparam logic [31:0] BB = 32'h05060708;
  localparam logic [63:0] BR = 64'h0013_0016_002B_0032;

  always #5 clk = ~clk;

  matmul_seq dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .res(res), .busy(busy), .done(done), .ovf(ovf)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] model(input logic [31:0] av, input logic [31:0] bv, output logic o);
    logic [63:0] m;
    int s;
    m = '0;
    o = 1'b0;
    for (int rr = 0; rr < 2; rr++)
      for (int cc = 0; cc < 2; cc++) begin
        s = 0;
        for (int kk = 0; kk < 2; kk++)
          s += int'($signed(av[8*(3-(rr*2+kk)) +: 8])) * int'($signed(bv[8*(3-(kk*2+cc)) +: 8]));
        if (s > 32767 || s < -32768) o = 1'b1;
`ifdef MATMUL_SAT_EN
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
`endif
        m[16*(3-(rr*2+cc)) +: 16] = 16'(s);
      end
    return m;
  endfunction

  task automatic run(input string tag, input logic [31:0] av, input logic [31:0] bv);
    logic [63:0] e;
    logic        eo;
    int          cnt;
    e = model(av, bv, eo);
    a = av;
    b = bv;
    start = 1'b1;
    tick;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    cnt = 0;
    while (!done && cnt < 100) begin
      tick;
      cnt++;
    end
    check({tag, "_lat"}, 64'(cnt), 64'd12);
    check({tag, "_res"}, res, e);
    check({tag, "_ovf"}, 64'(ovf), 64'(eo));
    tick;
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int nd, cnt, seen, last;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    tick;
    tick;
    check("rst_res", res, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    rst = 1'b0;
    tick;

    run("basic", BA, BB);
    check("basic_const", res, BR);
    run("signed", 32'hFF0203FC, 32'h01000001);
    check("signed_const", res, 64'hFFFF_0002_0003_FFFC);
    run("ovf", 32'h80808080, 32'h80808080);
`ifdef MATMUL_SAT_EN
    check("ovf_const", res, 64'h7FFF_7FFF_7FFF_7FFF);
`else
    check("ovf_const", res, 64'h8000_8000_8000_8000);
`endif
    repeat (3) tick;
    check("ovf_sticky", 64'(ovf), 64'd1);
    run("ovf_clear", BA, BB);

    a = BA;
    b = BB;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    a = 32'h11111111;
    start = 1'b1;
    tick;
    start = 1'b0;
    nd = 0;
    repeat (40) begin
      tick;
      if (done) nd++;
    end
    check("ignore_ndone", 64'(nd), 64'd1);
    check("ignore_res", res, BR);

    a = BA;
    b = BB;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (5) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_res", res, 64'd0);
    nd = 0;
    repeat (20) begin
      tick;
      if (done) nd++;
    end
    check("abort_ndone", 64'(nd), 64'd0);
    run("after_abort", BA, BB);

    a = BA;
    b = BB;
    start = 1'b1;
    tick;
    cnt = 0;
    seen = 0;
    last = 0;
    while (seen < 3 && cnt < 100) begin
      tick;
      cnt++;
      if (done) begin
        check("b2b_period", 64'(cnt - last), seen == 0 ? 64'd12 : 64'd14);
        check("b2b_res", res, BR);
        last = cnt;
        seen++;
        if (seen == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    check("b2b_count", 64'(seen), 64'd3);
    repeat (3) tick;
    check("b2b_idle", 64'(busy), 64'd0);

    repeat (20) run("rnd", $urandom, $urandom);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/matmul_seq.md
MATMUL_SEQ -- requirements
Module: matmul_seq

Interface
REQ-001 SHALL have parameter A_ROWS, default 2: rows of matrix A and of the result.
REQ-002 SHALL have parameter A_COLS, default 2: columns of A and rows of B; B row count is always A_COLS, so no dimension mismatch is possible.
REQ-003 SHALL have parameter B_COLS, default 2: columns of B and of the result.
REQ-004 SHALL have parameter DW, default 8: signed two's-complement element width of A and B.
REQ-005 SHALL have parameter RW, default 16: signed element width of the result.
REQ-006 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port start, input, 1 bit: request to compute, sampled only in IDLE.
REQ-009 SHALL have port a, input, A_ROWS*A_COLS*DW bits: matrix A, packed as below.
REQ-010 SHALL have port b, input, A_COLS*B_COLS*DW bits: matrix B, packed as below.
REQ-011 SHALL have port res, output, A_ROWS*B_COLS*RW bits: result matrix, packed as below.
REQ-012 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-014 SHALL have port ovf, output, 1 bit: sticky overflow flag for the current or last run.
REQ-015 SHALL pack every matrix row-major, MSB-first: element (r,c) of an R x C matrix of width W occupies bits [W*(R*C-1-(r*C+c)) +: W].

Function
REQ-016 SHALL implement the FSM IDLE -> MAC -> STORE -> (MAC | DONE) -> IDLE.
REQ-017 In IDLE with start=1, the edge SHALL: capture a and b into internal registers; clear the accumulator, i, j and k; clear ovf; enter MAC.
- Later changes on a and b SHALL have no effect on the run.
REQ-018 Each MAC edge SHALL do acc += A[i][k]*B[k][j] (signed, full precision) and k++.
- On the edge where k==A_COLS-1, the state SHALL go to STORE.
REQ-019 The accumulator SHALL be 2*DW+$clog2(A_COLS) bits signed, so it never overflows internally.
REQ-020 The STORE edge SHALL: write the narrowed acc into res element (i,j); set ovf if acc lies outside the signed RW range; clear acc and k; advance j, then i.
- After the last element (i=A_ROWS-1, j=B_COLS-1), the state SHALL go to DONE; otherwise it SHALL go to MAC.
REQ-021 In DONE, done SHALL be 1 for exactly one cycle, and the next edge SHALL go to IDLE.
REQ-022 Latency: done SHALL rise A_ROWS*B_COLS*(A_COLS+1) edges after the accepting edge (12 for the defaults).
- Minimum start-to-start period SHALL be that latency + 2 edges.
REQ-023 start while busy (MAC, STORE or DONE) SHALL be ignored, with no queuing.
REQ-024 res elements SHALL keep their previous values until overwritten in STORE.
- res SHALL be fully valid from the done cycle until the next accepted start.
REQ-025 ovf SHALL hold its value from DONE until the next accepted start or rst.

Reset
REQ-026 rst=1 at an edge SHALL force: state IDLE, busy 0, done 0, ovf 0, res 0, acc 0, i/j/k 0, captured matrices 0.
REQ-027 rst SHALL take priority over start and over any state, and SHALL abort a run mid-operation with no done pulse.

Configuration
REQ-028 With macro MATMUL_SAT_EN defined, STORE SHALL saturate out-of-range acc to 2^(RW-1)-1 or -2^(RW-1).
REQ-029 Without MATMUL_SAT_EN, STORE SHALL keep the low RW bits of acc (two's-complement wrap).
REQ-030 ovf behaviour SHALL be identical in both builds.

Verification (defaults 2x2x2, DW=8, RW=16)
REQ-031 Basic: a=0x01020304, b=0x05060708, start pulse -> done 12 edges after acceptance; res=0x0013_0016_002B_0032; ovf=0.
REQ-032 Signed: a=0xFF0203FC, b=0x01000001 (identity) -> res=0xFFFF_0002_0003_FFFC; ovf=0.
REQ-033 Overflow: a=b=0x80808080 -> every element is 32768; ovf=1.
- With MATMUL_SAT_EN: res=0x7FFF_7FFF_7FFF_7FFF.
- Without it: res=0x8000_8000_8000_8000.
REQ-034 Busy ignore: repeat REQ-031 and pulse start again 5 edges after acceptance with a changed -> exactly one done; res as in REQ-031.
REQ-035 Mid-run reset: rst high at edge 6 of a run -> busy=0, done=0, res=0 next cycle and no done; a new start then reproduces REQ-031.
REQ-036 Back-to-back: start held high -> done pulses every 14 edges, each with the REQ-031 result.
